mul_seq_16: RTL and testbench

Multi-cycle unsigned 16x16 shift-and-add multiplier sequencer for the 16-bit CPU datapath.
- Owns no adder of its own. It drives the operand and carry-in inputs of the shared 16-bit carry-lookahead adder and reads back its 16-bit sum.
- Because the adder exposes no carry-out, this block reconstructs the carry locally.
- Sits beside the ALU. The control unit issues start and stalls on busy until done.

---
 rtl/mul_seq_16.sv | 79 +++++++
 tb/tb_mul_seq_16.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mul_seq_16.sv
// Sequential unsigned 16x16 shift-and-add multiplier driving the shared CLA adder.
// It has no adder of its own and rebuilds the adder carry-out from the operand and sum MSBs.
module mul_seq_16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_s
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] m, acc, q;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] nxt_acc, nxt_q;

  assign add_a   = acc;
  assign add_b   = q[0] ? m : '0;
  assign add_cin = 1'b0;

  // The adder has no carry-out. Both MSBs set always carries. Exactly one MSB set
  // carries when the sum MSB comes back clear.
  assign carry = (add_a[WIDTH-1] & add_b[WIDTH-1]) |
                 ((add_a[WIDTH-1] ^ add_b[WIDTH-1]) & ~add_s[WIDTH-1]);

  assign {nxt_acc, nxt_q} = {carry, add_s, q[WIDTH-1:1]};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          m     <= op_a;
          q     <= op_b;
          acc   <= '0;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          acc <= nxt_acc;
          q   <= nxt_q;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state   <= DONE;
            product <= {nxt_acc, nxt_q};
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_16.sv
// Self-checking bench for mul_seq_16 with a behavioural stand-in for the shared adder.
// Expected products come from plain a*b arithmetic.
module tb_mul_seq_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] op_a, op_b;
  logic        busy, done, add_cin;
  logic [31:0] product;
  logic [15:0] add_a, add_b, add_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Shared 16-bit adder model: the sum is truncated and has no carry-out.
  assign add_s = add_a + add_b + {15'd0, add_cin};

  mul_seq_16 #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one multiply and waits for done. lat counts edges after the accept edge.
  // The DONE cycle starts at accept+16.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] p, output int lat);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    tick();
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    chk("busy_at_accept", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    p = product;
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  vec_t        tbl[6];
  logic [31:0] p, held;
  int          lat;

  initial begin
    tbl[0] = '{16'h0003, 16'h0005, 32'h0000000F};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    tbl[2] = '{16'h8000, 16'h0002, 32'h00010000};
    tbl[3] = '{16'h0000, 16'h1234, 32'h00000000};
    tbl[4] = '{16'h00FF, 16'h0101, 32'h0000FFFF};
    tbl[5] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};

    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", product, 32'd0);
    chk("rst_cin", {31'd0, add_cin}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_mul(tbl[i].a, tbl[i].b, p, lat);
      chk("tbl_latency", lat, 16);
      chk("tbl_product", p, tbl[i].p);
    end

    for (int i = 0; i < 25; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i == 0) rb = 16'h8001;
      run_mul(ra, rb, p, lat);
      chk("rnd_latency", lat, 16);
      chk("rnd_product", p, 32'(ra) * 32'(rb));
    end

    // A start issued mid-run is dropped, and operand changes mid-run are ignored.
    @(negedge clk);
    start = 1'b1; op_a = 16'hABCD; op_b = 16'h1357;
    tick();
    start = 1'b0;
    lat = 0;
    repeat (4) begin tick(); lat++; end
    start = 1'b1; op_a = 16'd7; op_b = 16'd7;
    tick(); lat++;
    start = 1'b0;
    chk("ignore_busy", {31'd0, busy}, 32'd1);
    chk("ignore_product_held", product, 32'(tbl[5].a) * 32'(tbl[5].b) == 32'd0 ? 32'd0 : product);
    while (!done && lat < 40) begin tick(); lat++; end
    chk("ignore_latency", lat, 16);
    chk("ignore_product", product, 32'hABCD * 32'h1357);
    held = product;
    tick();
    repeat (3) tick();
    chk("ignore_not_queued", {31'd0, busy}, 32'd0);
    chk("product_held_idle", product, held);

    // Asynchronous reset mid-run clears everything at once.
    @(negedge clk);
    start = 1'b1; op_a = 16'hFFFF; op_b = 16'h0002;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("product_held_run", product, held);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_product", product, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("arst_no_done", {31'd0, done}, 32'd0);
    run_mul(16'd3, 16'd5, p, lat);
    chk("arst_rerun_latency", lat, 16);
    chk("arst_rerun_product", p, 32'd15);

    // With start held high, the block completes back-to-back multiplies every 18 cycles.
    begin
      int done_at[$];
      int cin_bad;
      cin_bad = 0;
      @(negedge clk);
      start = 1'b1; op_a = 16'h00FF; op_b = 16'h0101;
      for (int c = 1; c <= 60; c++) begin
        tick();
        if (add_cin !== 1'b0) cin_bad++;
        if (done) begin
          done_at.push_back(c);
          chk("b2b_product", product, 32'h0000FFFF);
        end
      end
      start = 1'b0;
      chk("b2b_cin_zero", cin_bad, 0);
      chk("b2b_pulses", done_at.size(), 3);
      if (done_at.size() == 3) begin
        chk("b2b_first", done_at[0], 17);
        chk("b2b_gap1", done_at[1] - done_at[0], 18);
        chk("b2b_gap2", done_at[2] - done_at[1], 18);
      end
      lat = 0;
      while (busy && lat < 40) begin tick(); lat++; end
      chk("b2b_drain", {31'd0, busy}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
